game_mmio_bridge: RTL and testbench

Memory-mapped bridge between the processor data-memory port and the game's per-player I/O. It generalises the fixed two-player edge/score path to NUM_PLAYERS channels. It adds synchronised edge sampling, sticky change flags with an event output, freeze-able snapshots, and saturating score increment with win detection. It sits beside RAM on the dmem bus and claims a configurable address window.

---
 rtl/game_mmio_bridge.sv | 143 ++++++++++++++
 tb/tb_game_mmio_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_mmio_bridge.sv
// Memory-mapped bridge between the dmem port and per-player edge/score I/O.
// It synchronises and snapshots the edges, keeps sticky change flags and saturating scores, and detects a winner.
module game_mmio_bridge #(
  parameter int                    NUM_PLAYERS = 2,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 12'hF00,
  parameter int                    SCORE_MAX   = 99
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              wren,
  input  logic [ADDR_WIDTH-1:0]             address_dmem,
  input  logic [DATA_WIDTH-1:0]             data,
  output logic [DATA_WIDTH-1:0]             q_mmio,
  output logic                              mmio_hit,
  input  logic [NUM_PLAYERS*DATA_WIDTH-1:0] edge_in,
  output logic [NUM_PLAYERS*DATA_WIDTH-1:0] score_out,
  output logic                              event_pending,
  output logic                              winner_valid
);

  localparam logic [3:0] OFF_STATUS = 4'd12;
  localparam logic [3:0] OFF_CTRL   = 4'd13;
  localparam logic [3:0] OFF_INC    = 4'd14;
  localparam logic [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(SCORE_MAX);

  logic [DATA_WIDTH-1:0]  sync1_q [NUM_PLAYERS];
  logic [DATA_WIDTH-1:0]  sync2_q [NUM_PLAYERS];
  logic [DATA_WIDTH-1:0]  edge_q  [NUM_PLAYERS];
  logic [DATA_WIDTH-1:0]  score_q [NUM_PLAYERS];
  logic [DATA_WIDTH-1:0]  score_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] flag_q, flag_d, chg, clr;
  logic                   freeze_q, freeze_d;
  logic                   win_q, win_d, win_any;
  logic [7:0]             widx_q, widx_d, win_low;
  logic                   hit_q;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata;
  logic                   hit, wr;
  logic [3:0]             off;

  // The window is 16-aligned, so a hit is a match on the upper address bits.
  assign hit = (address_dmem[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign off = address_dmem[3:0];
  assign wr  = wren & hit;

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      chg[i] = !freeze_q && (sync2_q[i] != edge_q[i]);
    end
    clr      = (wr && off == OFF_STATUS) ? data[NUM_PLAYERS-1:0] : '0;
    // A new change on the same flag outranks its write-1-to-clear.
    flag_d   = (flag_q & ~clr) | chg;
    freeze_d = (wr && off == OFF_CTRL) ? data[0] : freeze_q;
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_d[i] = score_q[i];
      if (wr && off == 4'(8 + i)) begin
        score_d[i] = (data > SMAX) ? SMAX : data;
      end else if (wr && off == OFF_INC && data[i] && score_q[i] < SMAX) begin
        score_d[i] = score_q[i] + DATA_WIDTH'(1);
      end
    end
  end

  always_comb begin
    win_any = 1'b0;
    win_low = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (score_q[i] == SMAX) begin
        win_any = 1'b1;
        win_low = 8'(i);
      end
    end
    win_d  = win_q;
    widx_d = widx_q;
    if (wr && off == OFF_STATUS && data[16]) begin
      win_d  = 1'b0;
      widx_d = '0;
    end else if (!win_q && win_any) begin
      win_d  = 1'b1;
      widx_d = win_low;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (off == 4'(i))     rdata = edge_q[i];
      if (off == 4'(8 + i)) rdata = score_q[i];
    end
    if (off == OFF_STATUS) begin
      rdata[NUM_PLAYERS-1:0] = flag_q;
      rdata[15:8]            = widx_q;
      rdata[16]              = win_q;
    end
    if (off == OFF_CTRL) rdata[0] = freeze_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        sync1_q[i] <= '0;
        sync2_q[i] <= '0;
        edge_q[i]  <= '0;
        score_q[i] <= '0;
      end
      flag_q   <= '0;
      freeze_q <= 1'b0;
      win_q    <= 1'b0;
      widx_q   <= '0;
      hit_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        sync1_q[i] <= edge_in[i*DATA_WIDTH +: DATA_WIDTH];
        sync2_q[i] <= sync1_q[i];
        if (!freeze_q) edge_q[i] <= sync2_q[i];
        score_q[i] <= score_d[i];
      end
      flag_q   <= flag_d;
      freeze_q <= freeze_d;
      win_q    <= win_d;
      widx_q   <= widx_d;
      hit_q    <= hit;
      rdata_q  <= hit ? rdata : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_out[i*DATA_WIDTH +: DATA_WIDTH] = score_q[i];
    end
  end

  assign q_mmio        = rdata_q;
  assign mmio_hit      = hit_q;
  assign event_pending = |flag_q;
  assign winner_valid  = win_q;

endmodule

// File: tb/tb_game_mmio_bridge.sv
// Bench for game_mmio_bridge: directed scenarios then random bus/edge traffic.
// A reference model queues expected read data; a negedge monitor pops and compares.
module tb_game_mmio_bridge;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam logic [AW-1:0] BASE = 12'hF00;
  localparam logic [DW-1:0] SMAX_V = 32'd99;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wren = 1'b0;
  logic [AW-1:0]     address_dmem = '0;
  logic [DW-1:0]     data = '0;
  logic [DW-1:0]     q_mmio;
  logic              mmio_hit;
  logic [NP*DW-1:0]  edge_in = '0;
  logic [NP*DW-1:0]  score_out;
  logic              event_pending;
  logic              winner_valid;

  game_mmio_bridge #(
    .NUM_PLAYERS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .SCORE_MAX(99)
  ) dut (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem), .data(data),
    .q_mmio(q_mmio), .mmio_hit(mmio_hit), .edge_in(edge_in), .score_out(score_out),
    .event_pending(event_pending), .winner_valid(winner_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Snapshot = edge input sampled two edges earlier, unless frozen.
  logic [DW-1:0] m_snap[NP], m_score[NP], m_in1[NP], m_in2[NP];
  logic [NP-1:0] m_flag = '0;
  logic          m_frz = 1'b0, m_wv = 1'b0;
  logic [7:0]    m_widx = '0;

  function automatic logic [DW-1:0] model_read(input logic [3:0] off);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) begin
      if (off == 4'(i))     r = m_snap[i];
      if (off == 4'(8 + i)) r = m_score[i];
    end
    if (off == 4'd12) r = {15'd0, m_wv, m_widx, 6'd0, m_flag};
    if (off == 4'd13) r = {31'd0, m_frz};
    return r;
  endfunction

  always @(posedge clock) begin : model
    logic       hit, wr, found;
    logic [3:0] off;
    logic [7:0] low;
    if (reset) begin
      for (int i = 0; i < NP; i++) begin
        m_snap[i] = '0; m_score[i] = '0; m_in1[i] = '0; m_in2[i] = '0;
      end
      m_flag = '0; m_frz = 1'b0; m_wv = 1'b0; m_widx = '0;
    end else begin
      hit = (address_dmem >= BASE) && (address_dmem < BASE + 12'd16);
      off = 4'(address_dmem - BASE);
      wr  = wren && hit;
      if (hit) exp_q.push_back(model_read(off));
      found = 1'b0; low = '0;
      for (int i = 0; i < NP; i++) begin
        if (!found && m_score[i] == SMAX_V) begin found = 1'b1; low = 8'(i); end
      end
      if (wr && off == 4'd12 && data[16]) begin
        m_wv = 1'b0; m_widx = '0;
      end else if (!m_wv && found) begin
        m_wv = 1'b1; m_widx = low;
      end
      if (wr && off == 4'd12) m_flag = m_flag & ~data[NP-1:0];
      for (int i = 0; i < NP; i++) begin
        if (!m_frz && m_in2[i] != m_snap[i]) begin
          m_snap[i] = m_in2[i];
          m_flag[i] = 1'b1;
        end
        m_in2[i] = m_in1[i];
        m_in1[i] = edge_in[i*DW +: DW];
        if (wr && off == 4'(8 + i)) m_score[i] = (data > SMAX_V) ? SMAX_V : data;
        if (wr && off == 4'd14 && data[i] && m_score[i] < SMAX_V) m_score[i] = m_score[i] + 1;
      end
      if (wr && off == 4'd13) m_frz = data[0];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (mon_en) begin
      if (mmio_hit) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rd_unexpected: got 0x%0h with no expected entry at %0t", q_mmio, $time);
        end else begin
          check("rd_data", q_mmio, exp_q.pop_front());
        end
      end
      for (int i = 0; i < NP; i++) check($sformatf("score_out[%0d]", i), score_out[i*DW +: DW], m_score[i]);
      check("event_pending", {31'd0, event_pending}, {31'd0, |m_flag});
      check("winner_valid", {31'd0, winner_valid}, {31'd0, m_wv});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren = w; address_dmem = a; data = d;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 12'h000, '0);
  endtask

  initial begin
    logic [3:0] off;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    // 1: reset and idle
    reset = 1'b1;
    idle(1);
    mon_en = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("p1_score_out", score_out[DW-1:0] | score_out[2*DW-1:DW], '0);
    check("p1_hit", {31'd0, mmio_hit}, '0);
    cycle(1'b0, BASE + 12'd12, '0);
    check("p1_status", q_mmio, '0);
    // 2: edge change on player 1, three-cycle latency, then W1C
    edge_in[DW +: DW] = 32'h0000_0140;
    idle(2);
    check("p2_pending_early", {31'd0, event_pending}, '0);
    idle(1);
    check("p2_pending", {31'd0, event_pending}, 32'd1);
    cycle(1'b0, BASE + 12'd1, '0);
    check("p2_edge1", q_mmio, 32'h140);
    cycle(1'b1, BASE + 12'd12, 32'h2);
    check("p2_cleared", {31'd0, event_pending}, '0);
    // 3: freeze holds snapshots
    cycle(1'b1, BASE + 12'd13, 32'h1);
    edge_in[0 +: DW] = 32'h55;
    idle(5);
    check("p3_frozen_flag", {31'd0, event_pending}, '0);
    cycle(1'b0, BASE + 12'd0, '0);
    check("p3_frozen_edge", q_mmio, '0);
    cycle(1'b1, BASE + 12'd13, 32'h0);
    idle(3);
    check("p3_thaw_flag", {31'd0, event_pending}, 32'd1);
    cycle(1'b0, BASE + 12'd0, '0);
    check("p3_thaw_edge", q_mmio, 32'h55);
    cycle(1'b1, BASE + 12'd12, 32'h3);
    // 4: saturation and win
    cycle(1'b1, BASE + 12'd8, 32'd150);
    check("p4_sat", score_out[0 +: DW], 32'd99);
    idle(1);
    check("p4_win", {31'd0, winner_valid}, 32'd1);
    cycle(1'b0, BASE + 12'd12, '0);
    check("p4_status", q_mmio, 32'h0001_0000);
    cycle(1'b1, BASE + 12'd14, 32'h1);
    check("p4_inc_sat", score_out[0 +: DW], 32'd99);
    // 5: simultaneous events
    cycle(1'b1, BASE + 12'd8, 32'd98);
    cycle(1'b1, BASE + 12'd9, 32'd98);
    cycle(1'b1, BASE + 12'd12, 32'h0001_0000);
    check("p5_win_clr", {31'd0, winner_valid}, '0);
    edge_in[0 +: DW] = 32'h77;
    idle(2);
    cycle(1'b1, BASE + 12'd12, 32'h1);
    check("p5_set_wins", {31'd0, event_pending}, 32'd1);
    cycle(1'b1, BASE + 12'd14, 32'h3);
    check("p5_inc0", score_out[0 +: DW], 32'd99);
    check("p5_inc1", score_out[DW +: DW], 32'd99);
    idle(1);
    cycle(1'b0, BASE + 12'd12, '0);
    check("p5_status", q_mmio, 32'h0001_0001);
    // 6: reset beats a same-cycle INC
    reset = 1'b1;
    cycle(1'b1, BASE + 12'd14, 32'h3);
    check("p6_score", score_out[DW-1:0] | score_out[2*DW-1:DW], '0);
    check("p6_pending", {31'd0, event_pending}, '0);
    check("p6_win", {31'd0, winner_valid}, '0);
    reset = 1'b0;
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) edge_in[$urandom_range(0, NP-1)*DW +: DW] = $urandom_range(0, 3);
      off = 4'($urandom_range(0, 15));
      case (off)
        4'd8, 4'd9: d = $urandom_range(90, 130);
        4'd12:      d = $urandom & 32'h0001_00FF;
        4'd13:      d = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0;
        4'd14:      d = $urandom_range(0, 3);
        default:    d = $urandom;
      endcase
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 12'hEFF)) : BASE + {8'd0, off};
      reset = ($urandom_range(0, 299) == 0);
      cycle(1'($urandom_range(0, 1)), a, d);
    end
    reset = 1'b0;
    idle(3);
    check("exp_q_drained", 32'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
